rs_enc_ctrl: RTL and testbench



---
 rtl/rs_pkg.sv | 45 ++++
 rtl/rs_sym_cnt.sv | 30 +++
 rtl/rs_enc_ctrl.sv | 130 +++++++++++++
 tb/tb_rs_enc_ctrl.sv | 373 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rs_pkg.sv
// Constants, state encoding and GF(2^8) helpers shared by the RS(255,239) encoder
// controller and the LFSR remainder datapath it sequences.
package rs_pkg;
  localparam int RS_N  = 255;
  localparam int RS_K  = 239;
  localparam int RS_P  = RS_N - RS_K;
  localparam int SYM_W = 8;

  // Low byte of the field polynomial x^8 + x^4 + x^3 + x^2 + 1.
  localparam logic [SYM_W-1:0] GF_POLY_LO = 8'h1D;

  typedef enum logic [1:0] {
    ST_CLR = 2'd0,
    ST_MSG = 2'd1,
    ST_PAR = 2'd2
  } rs_state_e;

  function automatic logic [SYM_W-1:0] gf_mul(input logic [SYM_W-1:0] a,
                                              input logic [SYM_W-1:0] b);
    logic [SYM_W-1:0] acc;
    logic [SYM_W-1:0] x;
    acc = '0;
    x   = a;
    for (int i = 0; i < SYM_W; i++) begin
      if (b[i]) acc = acc ^ x;
      x = x[SYM_W-1] ? ({x[SYM_W-2:0], 1'b0} ^ GF_POLY_LO) : {x[SYM_W-2:0], 1'b0};
    end
    return acc;
  endfunction

  // Coefficient j of the monic generator g(x) = prod_{i<p} (x + alpha^i), alpha = 2.
  function automatic logic [SYM_W-1:0] rs_gen_coef(input int p, input int j);
    logic [SYM_W-1:0] g [0:RS_N];
    logic [SYM_W-1:0] root;
    for (int i = 0; i <= RS_N; i++) g[i] = '0;
    g[0] = 8'h01;
    root = 8'h01;
    for (int i = 0; i < p; i++) begin
      for (int k = i + 1; k >= 1; k--) g[k] = g[k-1] ^ gf_mul(g[k], root);
      g[0] = gf_mul(g[0], root);
      root = gf_mul(root, 8'h02);
    end
    return g[j];
  endfunction
endpackage

// File: rtl/rs_sym_cnt.sv
// Symbol counter shared by the message and parity phases: counts enabled steps up to
// a selectable limit, flags the terminal count and wraps to zero on it.
module rs_sym_cnt
#(
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          en,
  input  logic [CW-1:0] limit,
  output logic [CW-1:0] cnt,
  output logic          tc
);
  logic [CW-1:0] cnt_q, cnt_d;

  assign tc  = (cnt_q == limit);
  assign cnt = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr)     cnt_d = '0;
    else if (en) cnt_d = tc ? '0 : cnt_q + CW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end
endmodule

// File: rtl/rs_enc_ctrl.sv
// Sequencer for the systematic RS encoder LFSR: passes K message symbols through while
// dividing, then shifts out P parity symbols with feedback gated off.
//   state | meaning
//   CLR   | one cycle, clear all remainder registers
//   MSG   | pass-through of message symbols, LFSR in feedback mode
//   PAR   | shift parity out of the LFSR with zero fill
module rs_enc_ctrl
  import rs_pkg::*;
#(
  parameter int N  = RS_N,
  parameter int K  = RS_K,
  parameter int CW = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             abort,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [SYM_W-1:0] s_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [SYM_W-1:0] m_data,
  output logic             m_last,
  input  logic [SYM_W-1:0] par_sym,
  output logic             lfsr_en,
  output logic             lfsr_fb,
  output logic             lfsr_clr,
  output logic [CW-1:0]    sym_idx,
  output logic             busy
);
  localparam int P = N - K;

  if (P < 1) begin : g_bad_p
    $error("rs_enc_ctrl: N-K must be at least 1");
  end
  if ((2 ** CW) <= K || (2 ** CW) <= P) begin : g_bad_cw
    $error("rs_enc_ctrl: CW too narrow for K or P");
  end

  rs_state_e     state_q, state_d, state_dec;
  logic          busy_q, busy_d;
  logic          cnt_clr, cnt_en, cnt_tc;
  logic [CW-1:0] cnt, cnt_lim;

  assign cnt_lim = (state_q == ST_PAR) ? CW'(P - 1) : CW'(K - 1);

  rs_sym_cnt #(.CW(CW)) u_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (cnt_clr),
    .en    (cnt_en),
    .limit (cnt_lim),
    .cnt   (cnt),
    .tc    (cnt_tc)
  );

  always_comb begin
    // While rst is high the outputs already look like CLR.
    state_dec = rst ? ST_CLR : state_q;
    state_d   = state_q;
    busy_d    = busy_q;
    cnt_clr   = 1'b0;
    cnt_en    = 1'b0;
    s_ready   = 1'b0;
    m_valid   = 1'b0;
    m_data    = '0;
    m_last    = 1'b0;
    lfsr_en   = 1'b0;
    lfsr_fb   = 1'b0;
    lfsr_clr  = 1'b0;
    case (state_dec)
      ST_CLR: begin
        lfsr_clr = 1'b1;
        cnt_clr  = 1'b1;
        state_d  = ST_MSG;
      end
      ST_MSG: begin
        s_ready = m_ready;
        m_valid = s_valid;
        m_data  = s_data;
        lfsr_fb = 1'b1;
        lfsr_en = s_valid && m_ready;
        cnt_en  = lfsr_en;
        if (lfsr_en) begin
          busy_d = 1'b1;
          if (cnt_tc) state_d = ST_PAR;
        end
      end
      ST_PAR: begin
        m_valid = 1'b1;
        m_data  = par_sym;
        m_last  = cnt_tc;
        lfsr_en = m_ready;
        cnt_en  = m_ready;
        // Zero-fill shifts leave the remainder cleared, so no CLR between codewords.
        if (m_ready && cnt_tc) begin
          busy_d  = 1'b0;
          state_d = ST_MSG;
        end
      end
      default: begin
        cnt_clr = 1'b1;
        state_d = ST_CLR;
      end
    endcase
    if (abort && !rst) begin
      s_ready = 1'b0;
      m_valid = 1'b0;
      m_last  = 1'b0;
      lfsr_en = 1'b0;
      cnt_en  = 1'b0;
      cnt_clr = 1'b1;
      busy_d  = 1'b0;
      state_d = ST_CLR;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_CLR;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
    end
  end

  assign sym_idx = rst ? '0 : cnt;
  assign busy    = busy_q;
endmodule

// File: tb/tb_rs_enc_ctrl.sv
// Scoreboard bench for rs_enc_ctrl: an LFSR datapath model closes the loop, and expected
// parity comes from plain polynomial long division over GF(2^8).
module tb_rs_enc_ctrl;
  import rs_pkg::*;

  localparam int K  = RS_K;
  localparam int P  = RS_P;
  localparam int K2 = 3;
  localparam int P2 = 4;

  typedef struct { logic [7:0] data; logic last; logic par; } exp_t;
  typedef struct { logic [7:0] data; logic [2:0] idx; logic last; } obs_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       abort = 1'b0;
  logic       s_valid = 1'b0;
  logic [7:0] s_data = 8'h00;
  logic       m_ready = 1'b1;
  logic       s_ready, m_valid, m_last, lfsr_en, lfsr_fb, lfsr_clr, busy;
  logic [7:0] m_data, par_sym, sym_idx;

  logic       abort2 = 1'b0;
  logic       s_valid2 = 1'b0;
  logic [7:0] s_data2 = 8'h00;
  logic       m_ready2 = 1'b1;
  logic       s_ready2, m_valid2, m_last2, lfsr_en2, lfsr_fb2, lfsr_clr2, busy2;
  logic [7:0] m_data2, par_sym2;
  logic [2:0] sym_idx2;

  int n_chk = 0;
  int n_pass = 0;
  int n_out = 0;
  int cyc = 0;
  int mr_mode = 0;

  exp_t       exp_q[$];
  obs_t       obs2_q[$];
  int         out_cyc[$];
  logic [7:0] send_q[$];
  logic [7:0] ref_msg [0:RS_N-1];
  logic [7:0] ref_par [0:RS_P-1];

  logic [7:0] gen1 [0:P];
  logic [7:0] gen2 [0:P2];
  logic [7:0] lfsr1 [0:P-1];
  logic [7:0] lfsr2 [0:P2-1];
  logic [7:0] fb1, fb2;

  always #5 clk = ~clk;

  rs_enc_ctrl u_dut (
    .clk(clk), .rst(rst), .abort(abort),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
    .par_sym(par_sym), .lfsr_en(lfsr_en), .lfsr_fb(lfsr_fb), .lfsr_clr(lfsr_clr),
    .sym_idx(sym_idx), .busy(busy)
  );

  rs_enc_ctrl #(.N(7), .K(3), .CW(3)) u_small (
    .clk(clk), .rst(rst), .abort(abort2),
    .s_valid(s_valid2), .s_ready(s_ready2), .s_data(s_data2),
    .m_valid(m_valid2), .m_ready(m_ready2), .m_data(m_data2), .m_last(m_last2),
    .par_sym(par_sym2), .lfsr_en(lfsr_en2), .lfsr_fb(lfsr_fb2), .lfsr_clr(lfsr_clr2),
    .sym_idx(sym_idx2), .busy(busy2)
  );

  // Remainder-register datapaths driven by the controller enables.
  assign par_sym  = lfsr1[P-1];
  assign fb1      = lfsr_fb ? (s_data ^ par_sym) : 8'h00;
  assign par_sym2 = lfsr2[P2-1];
  assign fb2      = lfsr_fb2 ? (s_data2 ^ par_sym2) : 8'h00;

  always @(posedge clk) begin
    if (lfsr_clr) begin
      for (int j = 0; j < P; j++) lfsr1[j] <= 8'h00;
    end else if (lfsr_en) begin
      lfsr1[0] <= gf_mul(fb1, gen1[0]);
      for (int j = 1; j < P; j++) lfsr1[j] <= lfsr1[j-1] ^ gf_mul(fb1, gen1[j]);
    end
  end

  always @(posedge clk) begin
    if (lfsr_clr2) begin
      for (int j = 0; j < P2; j++) lfsr2[j] <= 8'h00;
    end else if (lfsr_en2) begin
      lfsr2[0] <= gf_mul(fb2, gen2[0]);
      for (int j = 1; j < P2; j++) lfsr2[j] <= lfsr2[j-1] ^ gf_mul(fb2, gen2[j]);
    end
  end

  task automatic chk(input string nm, input int act, input int want);
    n_chk++;
    if (act == want) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, want, want);
  endtask

  // Parity = remainder of m(x) * x^p divided by g(x), highest degree first.
  task automatic calc_ref(input int k, input int p);
    logic [7:0] d [0:RS_N-1];
    logic [7:0] g [0:RS_P];
    logic [7:0] c;
    for (int j = 0; j <= p; j++) g[j] = rs_gen_coef(p, j);
    for (int i = 0; i < k + p; i++) d[i] = (i < k) ? ref_msg[i] : 8'h00;
    for (int i = 0; i < k; i++) begin
      c = d[i];
      for (int j = 1; j <= p; j++) d[i+j] = d[i+j] ^ gf_mul(c, g[p-j]);
    end
    for (int j = 0; j < p; j++) ref_par[j] = d[k+j];
  endtask

  task automatic fill_msg(input int mode);
    for (int i = 0; i < K; i++) ref_msg[i] = (mode == 0) ? 8'(i) : 8'($urandom_range(0, 255));
  endtask

  task automatic push_cw();
    calc_ref(K, P);
    for (int i = 0; i < K; i++) begin
      exp_q.push_back('{ref_msg[i], 1'b0, 1'b0});
      send_q.push_back(ref_msg[i]);
    end
    for (int j = 0; j < P; j++) exp_q.push_back('{ref_par[j], (j == P - 1), 1'b1});
  endtask

  task automatic send_syms(input int n);
    bit hs;
    int w;
    for (int i = 0; i < n; i++) begin
      s_valid = 1'b1;
      s_data  = send_q.pop_front();
      hs = 1'b0;
      w  = 0;
      while (!hs && w < 600) begin
        @(negedge clk);
        hs = s_ready && s_valid;
        w++;
      end
      if (!hs) begin
        chk("accept_timeout", 0, 1);
        break;
      end
      @(posedge clk); #1;
    end
    s_valid = 1'b0;
  endtask

  task automatic wait_drain(input int max_cyc);
    int w;
    w = 0;
    while (exp_q.size() != 0 && w < max_cyc) begin
      @(posedge clk); #1;
      w++;
    end
    chk("drain_timeout", exp_q.size(), 0);
  endtask

  initial begin : mr_drv
    forever begin
      @(posedge clk); #1;
      m_ready = (mr_mode == 0) || ($urandom_range(0, 1) == 1);
    end
  end

  initial begin : mon
    exp_t       e;
    logic       stall_prev;
    logic [7:0] stall_data;
    stall_prev = 1'b0;
    stall_data = 8'h00;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        stall_prev = 1'b0;
      end else begin
        chk("lfsr_en_vs_handshake", int'(lfsr_en), int'(m_valid && m_ready));
        if (stall_prev && !abort) begin
          chk("stall_valid", int'(m_valid), 1);
          chk("stall_data", int'(m_data), int'(stall_data));
        end
        if (m_valid && m_ready) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_output", 1, 0);
          end else begin
            e = exp_q.pop_front();
            chk("m_data", int'(m_data), int'(e.data));
            chk("m_last", int'(m_last), int'(e.last));
            chk("lfsr_fb", int'(lfsr_fb), int'(!e.par));
          end
          n_out++;
          out_cyc.push_back(cyc);
        end
        stall_prev = m_valid && !m_ready;
        stall_data = m_data;
      end
    end
  end

  initial begin : mon_small
    forever begin
      @(negedge clk);
      if (!rst && m_valid2 && m_ready2) obs2_q.push_back('{m_data2, sym_idx2, m_last2});
    end
  end

  initial begin : watchdog
    #800000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_chk);
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int base, w;
    bit hs;
    obs_t o;
    for (int j = 0; j <= P; j++)  gen1[j] = rs_gen_coef(P, j);
    for (int j = 0; j <= P2; j++) gen2[j] = rs_gen_coef(P2, j);

    // Reset, then idle.
    repeat (3) begin
      @(negedge clk);
      chk("rst_lfsr_clr", int'(lfsr_clr), 1);
      chk("rst_s_ready", int'(s_ready), 0);
      chk("rst_m_valid", int'(m_valid), 0);
      chk("rst_lfsr_en", int'(lfsr_en), 0);
      chk("rst_sym_idx", int'(sym_idx), 0);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("clr_after_rst", int'(lfsr_clr), 1);
    chk("clr_s_ready", int'(s_ready), 0);
    chk("clr_busy", int'(busy), 0);
    repeat (4) begin
      @(negedge clk);
      chk("idle_lfsr_clr", int'(lfsr_clr), 0);
      chk("idle_s_ready", int'(s_ready), 1);
      chk("idle_m_valid", int'(m_valid), 0);
      chk("idle_busy", int'(busy), 0);
    end
    @(posedge clk); #1;

    // Ramp message 0x00..0xEE, no stalls.
    fill_msg(0);
    push_cw();
    send_syms(K);
    chk("busy_in_par", int'(busy), 1);
    wait_drain(100);
    @(negedge clk);
    chk("busy_after_cw", int'(busy), 0);
    chk("idx_after_cw", int'(sym_idx), 0);
    @(posedge clk); #1;

    // Back-to-back random codewords with s_valid held.
    base = n_out;
    fill_msg(1);
    push_cw();
    fill_msg(1);
    push_cw();
    send_syms(2 * K);
    wait_drain(100);
    chk("b2b_outputs", n_out - base, 2 * RS_N);
    if (out_cyc.size() >= base + 2 * RS_N)
      chk("b2b_span", out_cyc[base + 2 * RS_N - 1] - out_cyc[base], 2 * RS_N - 1);

    // Random backpressure in both phases.
    mr_mode = 1;
    fill_msg(0);
    push_cw();
    send_syms(K);
    wait_drain(3000);
    fill_msg(1);
    push_cw();
    send_syms(K);
    wait_drain(3000);
    mr_mode = 0;
    repeat (2) begin @(posedge clk); #1; end

    // Abort at message symbol 100.
    fill_msg(1);
    push_cw();
    send_syms(100);
    abort   = 1'b1;
    s_valid = 1'b1;
    s_data  = 8'hA5;
    @(negedge clk);
    chk("abort_msg_idx", int'(sym_idx), 100);
    chk("abort_msg_s_ready", int'(s_ready), 0);
    chk("abort_msg_m_valid", int'(m_valid), 0);
    chk("abort_msg_lfsr_en", int'(lfsr_en), 0);
    @(posedge clk); #1;
    abort   = 1'b0;
    s_valid = 1'b0;
    exp_q.delete();
    send_q.delete();
    @(negedge clk);
    chk("abort_msg_clr", int'(lfsr_clr), 1);
    chk("abort_msg_busy", int'(busy), 0);
    chk("abort_msg_idx0", int'(sym_idx), 0);
    @(posedge clk); #1;
    fill_msg(1);
    push_cw();
    send_syms(K);
    wait_drain(100);

    // Abort at parity symbol 5.
    base = n_out;
    fill_msg(1);
    push_cw();
    send_syms(K);
    w = 0;
    while (n_out < base + K + 5 && w < 100) begin
      @(posedge clk); #1;
      w++;
    end
    chk("par5_reached", n_out - base, K + 5);
    abort = 1'b1;
    @(negedge clk);
    chk("abort_par_idx", int'(sym_idx), 5);
    chk("abort_par_m_valid", int'(m_valid), 0);
    chk("abort_par_lfsr_en", int'(lfsr_en), 0);
    chk("abort_par_m_last", int'(m_last), 0);
    @(posedge clk); #1;
    abort = 1'b0;
    exp_q.delete();
    @(negedge clk);
    chk("abort_par_clr", int'(lfsr_clr), 1);
    chk("abort_par_busy", int'(busy), 0);
    @(posedge clk); #1;
    fill_msg(1);
    push_cw();
    send_syms(K);
    wait_drain(100);

    // Small build: N=7, K=3.
    ref_msg[0] = 8'h01;
    ref_msg[1] = 8'h02;
    ref_msg[2] = 8'h03;
    calc_ref(K2, P2);
    for (int i = 0; i < K2; i++) begin
      s_valid2 = 1'b1;
      s_data2  = ref_msg[i];
      hs = 1'b0;
      w  = 0;
      while (!hs && w < 50) begin
        @(negedge clk);
        hs = s_ready2 && s_valid2;
        w++;
      end
      if (!hs) chk("small_accept_timeout", 0, 1);
      @(posedge clk); #1;
    end
    s_valid2 = 1'b0;
    w = 0;
    while (obs2_q.size() < K2 + P2 && w < 50) begin
      @(posedge clk); #1;
      w++;
    end
    repeat (5) begin @(posedge clk); #1; end
    chk("small_count", obs2_q.size(), K2 + P2);
    for (int i = 0; i < K2 + P2; i++) begin
      if (i < obs2_q.size()) begin
        o = obs2_q[i];
        chk("small_data", int'(o.data), (i < K2) ? int'(ref_msg[i]) : int'(ref_par[i - K2]));
        chk("small_idx", int'(o.idx), (i < K2) ? i : i - K2);
        chk("small_last", int'(o.last), (i == K2 + P2 - 1) ? 1 : 0);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
